// File: rtl/inv_first_round_if.sv
// -----------------------------------------------------------------------------
// inv_first_round_if
// Block-level handshake bundle for the first inverse AES round.
//   iValid / oReady : upstream valid/ready, with the iState and iKey payload
//   oValid / iReady : downstream valid/ready, with the oState payload
// Byte b of every 128-bit field occupies bits [8b:8b+7] (ascending range).
// The slave modport is the view of the round block. The master modport is the
// view of whoever drives the block.
// -----------------------------------------------------------------------------
interface inv_first_round_if;
    logic         iValid;
    logic         oReady;
    logic [0:127] iState;
    logic [0:127] iKey;
    logic [0:127] oState;
    logic         oValid;
    logic         iReady;

    modport slave (
        input  iValid, iState, iKey, iReady,
        output oReady, oState, oValid
    );

    modport master (
        output iValid, iState, iKey, iReady,
        input  oReady, oState, oValid
    );
endinterface

// File: rtl/inv_first_round.sv
// -----------------------------------------------------------------------------
// inv_first_round
// First round of the AES-128 inverse cipher:
//   oState = InvSubBytes(InvShiftRows(iState ^ iKey)), where iKey is round key 10.
// The block processes one column per cycle through four inverse S-boxes.
// Ports:
//   iClk   : clock, rising edge
//   iRst_n : asynchronous active-low reset
//   iEn    : global enable. While it is low, every register holds and oReady is 0.
//   bus    : handshake and data bundle (slave view), see inv_first_round_if
// Contains the combinational leaf inv_sbox, which is the AES inverse S-box.
// -----------------------------------------------------------------------------

// inv_sbox: 8-bit inverse S-box lookup, purely combinational.
//   iByte : input byte
//   oByte : InvSubBytes(iByte)
module inv_sbox (
    input  logic [7:0] iByte,
    output logic [7:0] oByte
);
    // Entry n occupies bits [8n:8n+7]. The first row of the table is entry 0.
    localparam logic [0:2047] INV_SBOX_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign oByte = INV_SBOX_TABLE[{iByte, 3'b000} +: 8];
endmodule

// State  | Meaning
// -------+-------------------------------------------------------------------
// IDLE   | Waiting for a block. oReady follows iEn.
// COL    | Writes oState column rCol each enabled cycle, for columns 0..3
// DONE   | oState and oValid are held until iReady is seen on an enabled edge
module inv_first_round (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iEn,
    inv_first_round_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COL  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT        rState;
    stateT        nState;
    logic [1:0]   rCol;
    logic [0:127] rTmp;
    logic [0:127] rOState;
    logic         rOValid;

    logic         readyInt;
    logic         doAccept;
    logic         doCol;
    logic         doRelease;
    logic [0:31]  colOut;

    // State register. The FSM advances only on cycles where iEn is high.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rState <= IDLE;
        end else if (iEn) begin
            rState <= nState;
        end
    end

    // Next-state logic
    always_comb begin
        nState = rState;
        case (rState)
            IDLE:    if (bus.iValid)    nState = COL;
            COL:     if (rCol == 2'd3)  nState = DONE;
            DONE:    if (bus.iReady)    nState = IDLE;
            default:                    nState = IDLE;
        endcase
    end

    // Output and control decode. oReady depends only on state and iEn, never on iValid.
    always_comb begin
        readyInt  = 1'b0;
        doAccept  = 1'b0;
        doCol     = 1'b0;
        doRelease = 1'b0;
        if (iEn) begin
            case (rState)
                IDLE: begin
                    readyInt = 1'b1;
                    doAccept = bus.iValid;
                end
                COL:     doCol     = 1'b1;
                DONE:    doRelease = bus.iReady;
                default: ;
            endcase
        end
    end

    // Output column rCol, row r, comes from rTmp row r, column (rCol - r) mod 4.
    // The 2-bit subtraction wraps, which gives the mod 4 for free.
    for (genvar r = 0; r < 4; r++) begin : gRow
        logic [1:0] srcCol;
        logic [3:0] byteIdx;
        logic [7:0] sbIn;
        logic [7:0] sbOut;

        assign srcCol  = rCol - 2'(r);
        assign byteIdx = {srcCol, 2'(r)};
        assign sbIn    = rTmp[{byteIdx, 3'b000} +: 8];

        inv_sbox uInvSbox (
            .iByte (sbIn),
            .oByte (sbOut)
        );

        assign colOut[8*r +: 8] = sbOut;
    end

    // Datapath registers
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rTmp    <= '0;
            rCol    <= 2'd0;
            rOState <= '0;
            rOValid <= 1'b0;
        end else begin
            if (doAccept) begin
                rTmp <= bus.iState ^ bus.iKey;
                rCol <= 2'd0;
            end
            if (doCol) begin
                rOState[{rCol, 5'b00000} +: 32] <= colOut;
                // Wraps from 3 back to 0, which leaves the counter ready for the next block
                rCol <= rCol + 2'd1;
                if (rCol == 2'd3) begin
                    rOValid <= 1'b1;
                end
            end
            if (doRelease) begin
                rOValid <= 1'b0;
            end
        end
    end

    assign bus.oReady = readyInt;
    assign bus.oState = rOState;
    assign bus.oValid = rOValid;
endmodule

// File: doc/inv_first_round.md
Name: inv_first_round

Overview:
- Decryption-side counterpart of the encryption last round in the AES-128 core.
- Computes InvSubBytes(InvShiftRows(iState XOR iKey)); iKey is round key 10.
- Iterative: one column per cycle through four byte-wide inverse S-boxes, each an instance of the combinational leaf inv_sbox (8-bit in, 8-bit out).
- Sits at the head of the inverse cipher datapath. Valid/ready handshake on both sides.

Parameters:
none

Ports:
iClk     input   1    clock, rising edge
iRst_n   input   1    asynchronous active-low reset
iEn      input   1    global enable; 0 freezes all state
iValid   input   1    input block valid
oReady   output  1    block can accept input
iState   input   128  ciphertext/state, [0:127]
iKey     input   128  round key 10, [0:127]
oState   output  128  round result, registered
oValid   output  1    oState valid
iReady   input   1    downstream accepts oState

Behaviour:
- Reset is asynchronous and active-low; the clock is iClk.
- Byte and column ordering:
  - Byte b (0..15) occupies bits [8b:8b+7].
  - Row r, column c is byte 4c+r.
- InvShiftRows: out[r][c] = in[r][(c-r) mod 4].
- FSM states: IDLE, COL, DONE. 2-bit column counter rCol.
- Reset (iRst_n=0), effective immediately regardless of iClk:
  - state=IDLE, rCol=0, rTmp=0, oState=0, oValid=0.
  - oReady goes to 1 once reset is released and iEn=1.
- oReady = (state==IDLE) && iEn. This is combinational from registered state; it has no path from iValid.
- Accept condition: iValid && oReady at a rising edge.
  - rTmp <= iState ^ iKey; state <= COL; rCol <= 0.
  - iState/iKey are sampled only on that edge; later changes are ignored.
- COL state, each edge with iEn=1:
  - Column rCol of InvShiftRows(rTmp) goes through the 4 inv_sbox instances.
  - The result is written into oState column rCol.
  - Other columns of oState are held.
  - rCol increments. When rCol==3: state <= DONE, oValid <= 1, rCol <= 0.
- Latency: accept at edge N; oValid=1 after edge N+4 with the complete result.
- DONE state: oState and oValid are held stable until iValid... no: held stable until iReady=1 at an edge with iEn=1. Then oValid <= 0 and state <= IDLE.
  - oState keeps its last value after the handshake; it is not cleared.
- Throughput: one block per 6 cycles minimum (accept, 4 columns, handshake). No input is accepted while in COL or DONE.
- iValid in COL or DONE is ignored; it is not queued.
- iEn=0: FSM, rCol, rTmp, oState and oValid are all frozen. oReady=0. A handshake with iReady=1 does not complete while iEn=0.
- Reset asserted mid-COL or mid-DONE aborts the block. No partial output is flagged valid.
- No arithmetic beyond XOR. All datapath widths are 128 bits or 8 bits; no truncation.

Test Plan:
- FIPS-197 C.1 vector:
  - Stimulus: iState=69c4e0d86a7b0430d8cdb78070b4c55a, iKey=13111d7fe3944a17f307a78b4d2b30c5, iReady=1.
  - Required: rTmp=7ad5fda789ef4e272bca100b3d9ff59f; oState=bd6e7c3df2b5779e0b61216e8b10b689 with oValid=1 exactly 4 edges after accept.
- Zero block:
  - Stimulus: iState=0, iKey=0.
  - Required: oState=5252...52 (inv_sbox(00)=52). Check each column updates in order 0,1,2,3 on successive edges.
- Backpressure:
  - Stimulus: hold iReady=0 for 10 cycles after oValid rises, with iValid=1 continuously and new data on iState.
  - Required: oState and oValid stable; oReady=0 throughout; no second accept. After iReady=1: oValid=0 next edge, oReady=1 in the following cycle.
- Stall:
  - Stimulus: deassert iEn for 3 cycles after column 1 is written, using the C.1 vector.
  - Required: rCol and oState frozen; oReady=0; final result still bd6e7c3d...b689; oValid rises 4+3 edges after accept.
- Async reset mid-operation:
  - Stimulus: drop iRst_n between clock edges during COL (rCol=2).
  - Required: oValid=0 and oState=0 immediately, without waiting for a clock edge; oReady=1 after release. A fresh C.1 block then completes correctly.
- Back-to-back:
  - Stimulus: two blocks with iValid held high and iReady=1.
  - Required: second accept occurs on the edge after the first handshake; both results are correct; accepts are spaced 6 cycles apart.
